wifi_tx_scheduler: RTL

Queues (command, data) byte pairs written by the J1 CPU and feeds them, one frame at a time, to the WiFi UART sender (`datos`/`comando`/`start_j1`/`bussy` interface). It sits between the J1 I/O decode and the sender. Firmware no longer has to poll `bussy` before every byte. A small FIFO decouples CPU writes from UART pacing. An FSM enforces the start/busy handshake and a minimum inter-frame gap.

---
 rtl/wifi_sched_pkg.sv | 28 ++
 rtl/wifi_cmd_fifo.sv | 47 ++++
 rtl/wifi_tx_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wifi_sched_pkg.sv
// Shared types and constants for the WiFi TX scheduler.
// The optional ACK timeout is selected with the WIFI_SCHED_TIMEOUT_EN macro.
package wifi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } sched_state_e;

  localparam logic [3:0] ADDR_PUSH   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;

  localparam int unsigned ST_BUSY  = 15;
  localparam int unsigned ST_EMPTY = 14;
  localparam int unsigned ST_FULL  = 13;
  localparam int unsigned ST_OVF   = 12;
  localparam int unsigned ST_TOUT  = 11;
  localparam int unsigned ST_CNT_W = 7;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_FLUSH = 1;
  localparam int unsigned CTRL_CLR   = 2;

endpackage

// File: rtl/wifi_cmd_fifo.sv
// Synchronous 16-bit FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter. Flush overrides push/pop.
module wifi_cmd_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [15:0]                data_i,
  output logic [15:0]                data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wifi_tx_scheduler.sv
// Queues J1 (cmd, dato) writes and launches them one frame at a time to the UART sender.
// Define WIFI_SCHED_TIMEOUT_EN to abandon frames whose busy never rises.
module wifi_tx_scheduler
  import wifi_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic [7:0]  snd_dato,
  output logic [7:0]  snd_cmd,
  output logic        snd_start,
  input  logic        snd_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e  state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          enable_q;
  logic          overflow_q;
  logic [7:0]    dato_q;
  logic [7:0]    cmd_q;
  logic          timeout_err;
  logic          timeout_hit;

  logic          push;
  logic          ctrl_wr;
  logic          flush;
  logic          clr;
  logic          pop;
  logic [15:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [15:0]   status;

  assign push    = cs && wr && (addr == ADDR_PUSH);
  assign ctrl_wr = cs && wr && (addr == ADDR_CTRL);
  assign flush   = ctrl_wr && d_in[CTRL_FLUSH];
  assign clr     = ctrl_wr && d_in[CTRL_CLR];

  wifi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (d_in),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef WIFI_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [TW-1:0] ack_cnt_q;
  logic          timeout_err_q;

  assign timeout_hit = (state_q == WAIT_ACK) && !snd_busy &&
                       (ack_cnt_q == TW'(ACK_TIMEOUT - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_cnt_q <= (state_q == WAIT_ACK) ? ack_cnt_q + TW'(1) : '0;
      if (clr)              timeout_err_q <= 1'b0;
      else if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:   state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (snd_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout_hit) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      WAIT_DONE: begin
        if (!snd_busy) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                  gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      dato_q     <= '0;
      cmd_q      <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      if (ctrl_wr) enable_q <= d_in[CTRL_EN];
      // a full FIFO drops the write even if the FSM pops on the same edge
      if (clr)                    overflow_q <= 1'b0;
      else if (push && fifo_full) overflow_q <= 1'b1;
      if (pop) begin
        cmd_q  <= fifo_head[15:8];
        dato_q <= fifo_head[7:0];
      end
    end
  end

  assign snd_start = (state_q == LAUNCH);
  assign snd_cmd   = cmd_q;
  assign snd_dato  = dato_q;

  always_comb begin
    status                 = '0;
    status[ST_BUSY]        = (state_q != IDLE);
    status[ST_EMPTY]       = fifo_empty;
    status[ST_FULL]        = fifo_full;
    status[ST_OVF]         = overflow_q;
    status[ST_TOUT]        = timeout_err;
    status[ST_CNT_W-1:0]   = ST_CNT_W'(fifo_count);
    d_out = (cs && rd && (addr == ADDR_STATUS)) ? status : '0;
  end

endmodule
